// File: rtl/rx_pkt_parser.sv
// Byte-stream packet parser: assembles big-endian words, decodes the packet type and
// commits node-info fields with a one-cycle en_MNI strobe; malformed packets raise pkt_err.
module rx_pkt_parser #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned MAX_WORDS  = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [BYTE_WIDTH-1:0] in_byte,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [2:0]            fPktType,
    output logic [WORD_WIDTH-1:0] src_id,
    output logic [WORD_WIDTH-1:0] hops,
    output logic [WORD_WIDTH-1:0] ch_ID,
    output logic [WORD_WIDTH-1:0] e_threshold,
    output logic [WORD_WIDTH-1:0] timeslot,
    output logic                  en_MNI,
    output logic                  pkt_err,
    output logic [7:0]            err_cnt
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned ERR_W = 8;

    localparam logic [2:0] T_HB  = 3'b000;
    localparam logic [2:0] T_CHE = 3'b001;
    localparam logic [2:0] T_TS  = 3'b100;
    localparam logic [2:0] T_NONE = 3'b111;

    typedef enum logic [2:0] {
        S_HDR,
        S_LEN,
        S_WHI,
        S_WLO,
        S_EMIT,
        S_DROP
    } state_t;

    state_t                state, state_d;
    logic [2:0]            pkt_type, pkt_type_d;
    logic [CNT_W-1:0]      n_words, n_words_d;
    logic [CNT_W-1:0]      idx, idx_d;
    logic [BYTE_WIDTH-1:0] hi_byte, hi_byte_d;
    logic [WORD_WIDTH-1:0] sh_src, sh_src_d;
    logic [WORD_WIDTH-1:0] sh_hops, sh_hops_d;
    logic [WORD_WIDTH-1:0] sh_ch, sh_ch_d;
    logic [WORD_WIDTH-1:0] sh_eth, sh_eth_d;
    logic [WORD_WIDTH-1:0] sh_ts, sh_ts_d;
    logic                  emit_d;
    logic                  err_d;
    logic                  xfer;
    logic [WORD_WIDTH-1:0] word;

    // Smallest payload that carries every field of the given type
    function automatic logic [BYTE_WIDTH-1:0] min_words(input logic [2:0] t);
        case (t)
            T_HB, T_TS: min_words = BYTE_WIDTH'(3);
            T_CHE:      min_words = BYTE_WIDTH'(2);
            default:    min_words = BYTE_WIDTH'(1);
        endcase
    endfunction

    // Next-state, shadow capture and strobe decode
    always_comb begin
        state_d    = state;
        pkt_type_d = pkt_type;
        n_words_d  = n_words;
        idx_d      = idx;
        hi_byte_d  = hi_byte;
        sh_src_d   = sh_src;
        sh_hops_d  = sh_hops;
        sh_ch_d    = sh_ch;
        sh_eth_d   = sh_eth;
        sh_ts_d    = sh_ts;
        emit_d     = 1'b0;
        err_d      = 1'b0;
        xfer       = in_valid & in_ready;
        word       = WORD_WIDTH'({hi_byte, in_byte});

        case (state)
            S_HDR: begin
                if (xfer) begin
                    pkt_type_d = in_byte[BYTE_WIDTH-1 -: 3];
                    if (in_last) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (xfer) begin
                    n_words_d = CNT_W'(in_byte);
                    idx_d     = '0;
                    if (in_last) begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end else if (in_byte == '0 || in_byte > BYTE_WIDTH'(MAX_WORDS)
                                 || in_byte < min_words(pkt_type)) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_WHI;
                    end
                end
            end
            S_WHI: begin
                if (xfer) begin
                    hi_byte_d = in_byte;
                    if (in_last) begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end else begin
                        state_d = S_WLO;
                    end
                end
            end
            S_WLO: begin
                if (xfer) begin
                    // Route the completed word into the shadow its type maps it to
                    case (idx)
                        CNT_W'(0): sh_src_d = word;
                        CNT_W'(1): begin
                            if (pkt_type == T_HB) sh_hops_d = word;
                            if (pkt_type == T_CHE || pkt_type == T_TS) sh_ch_d = word;
                        end
                        CNT_W'(2): begin
                            if (pkt_type == T_HB) sh_eth_d = word;
                            if (pkt_type == T_TS) sh_ts_d = word;
                        end
                        default: ;
                    endcase
                    if (idx == n_words - CNT_W'(1)) begin
                        if (in_last) begin
                            emit_d  = 1'b1;
                            state_d = S_EMIT;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (in_last) begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end else begin
                        idx_d   = idx + CNT_W'(1);
                        state_d = S_WHI;
                    end
                end
            end
            S_EMIT: state_d = S_HDR;
            S_DROP: begin
                if (xfer && in_last) begin
                    err_d   = 1'b1;
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // State, shadows and registered outputs; fields commit on the edge into EMIT
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= S_HDR;
            pkt_type    <= T_NONE;
            n_words     <= '0;
            idx         <= '0;
            hi_byte     <= '0;
            sh_src      <= '0;
            sh_hops     <= '0;
            sh_ch       <= '0;
            sh_eth      <= '0;
            sh_ts       <= '0;
            in_ready    <= 1'b1;
            fPktType    <= T_NONE;
            src_id      <= '0;
            hops        <= '0;
            ch_ID       <= '0;
            e_threshold <= '0;
            timeslot    <= '0;
            en_MNI      <= 1'b0;
            pkt_err     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state    <= state_d;
            pkt_type <= pkt_type_d;
            n_words  <= n_words_d;
            idx      <= idx_d;
            hi_byte  <= hi_byte_d;
            sh_src   <= sh_src_d;
            sh_hops  <= sh_hops_d;
            sh_ch    <= sh_ch_d;
            sh_eth   <= sh_eth_d;
            sh_ts    <= sh_ts_d;
            in_ready <= (state_d != S_EMIT);
            en_MNI   <= emit_d;
            pkt_err  <= err_d;
            if (err_d && err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (emit_d) begin
                fPktType <= pkt_type;
                src_id   <= sh_src_d;
                if (pkt_type == T_HB) begin
                    hops        <= sh_hops_d;
                    e_threshold <= sh_eth_d;
                end
                if (pkt_type == T_CHE || pkt_type == T_TS) begin
                    ch_ID <= sh_ch_d;
                end
                if (pkt_type == T_TS) begin
                    timeslot <= sh_ts_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_pkt_parser.sv
// Bench for rx_pkt_parser: directed packets, a packet-level reference model checked every
// cycle, and a few literal expectations on the known packets.
module tb_rx_pkt_parser;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [2:0]  fPktType;
    logic [15:0] src_id, hops, ch_ID, e_threshold, timeslot;
    logic        en_MNI, pkt_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    rx_pkt_parser dut (
        .clk(clk), .nrst(nrst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .fPktType(fPktType), .src_id(src_id), .hops(hops),
        .ch_ID(ch_ID), .e_threshold(e_threshold), .timeslot(timeslot),
        .en_MNI(en_MNI), .pkt_err(pkt_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: collects each packet's bytes, judges it whole on in_last
    logic [7:0]  rxq[$];
    bit          model_on = 0;
    logic        m_en, m_err, m_ready;
    logic [2:0]  m_type;
    logic [15:0] m_src, m_hops, m_ch, m_eth, m_ts;
    logic [7:0]  m_cnt;

    function automatic logic [15:0] qword(input int i);
        return {rxq[2 + 2 * i], rxq[3 + 2 * i]};
    endfunction

    task automatic judge();
        int n, nw, mw;
        logic [2:0] t;
        bit good;
        n = rxq.size();
        good = 0;
        t = 3'b111;
        if (n >= 2) begin
            t  = rxq[0][7:5];
            nw = int'(rxq[1]);
            mw = (t == 3'b000 || t == 3'b100) ? 3 : (t == 3'b001) ? 2 : 1;
            good = (nw >= mw) && (nw <= 16) && (n == 2 + 2 * nw);
        end
        if (good) begin
            m_en = 1; m_ready = 0; m_type = t; m_src = qword(0);
            if (t == 3'b000) begin m_hops = qword(1); m_eth = qword(2); end
            if (t == 3'b001) m_ch = qword(1);
            if (t == 3'b100) begin m_ch = qword(1); m_ts = qword(2); end
        end else begin
            m_err = 1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
    endtask

    always @(negedge clk) begin
        logic cur_ready;
        if (model_on) begin
            chk("en_MNI", 32'(en_MNI), 32'(m_en));
            chk("pkt_err", 32'(pkt_err), 32'(m_err));
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("fPktType", 32'(fPktType), 32'(m_type));
            chk("src_id", 32'(src_id), 32'(m_src));
            chk("hops", 32'(hops), 32'(m_hops));
            chk("ch_ID", 32'(ch_ID), 32'(m_ch));
            chk("e_threshold", 32'(e_threshold), 32'(m_eth));
            chk("timeslot", 32'(timeslot), 32'(m_ts));
        end
        cur_ready = m_ready;
        m_en = 0; m_err = 0; m_ready = 1;
        if (!nrst) begin
            m_type = 3'b111; m_src = '0; m_hops = '0; m_ch = '0; m_eth = '0; m_ts = '0;
            m_cnt = '0;
            rxq.delete();
            model_on = 1;
        end else if (model_on && in_valid && cur_ready) begin
            rxq.push_back(in_byte);
            if (in_last) begin
                judge();
                rxq.delete();
            end
        end
    end

    // Driver: present one byte, hold until accepted (bounded)
    task automatic send_byte(input logic [7:0] b, input logic last);
        bit done;
        done = 0;
        in_byte = b; in_valid = 1'b1; in_last = last;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL handshake byte %h never accepted", b);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    logic [7:0] pkt[$];

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], i == pkt.size() - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; in_byte = '0; in_valid = 1'b0; in_last = 1'b0;
        idle(2);
        nrst = 1'b1;
        chk("rst_fPktType", 32'(fPktType), 32'h7);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        idle(1);

        // HB: src 7, hops 2, e_threshold 0x01F4
        pkt = '{8'h00, 8'h03, 8'h00, 8'h07, 8'h00, 8'h02, 8'h01, 8'hF4};
        send_pkt();
        chk("hb_en", 32'(en_MNI), 32'h1);
        chk("hb_ready_stall", 32'(in_ready), 32'h0);
        chk("hb_type", 32'(fPktType), 32'h0);
        chk("hb_src", 32'(src_id), 32'h7);
        chk("hb_hops", 32'(hops), 32'h2);
        chk("hb_eth", 32'(e_threshold), 32'h01F4);
        idle(2);

        // CHE then TS back-to-back, valid held high across the EMIT stall
        pkt = '{8'h20, 8'h02, 8'h00, 8'h09, 8'h00, 8'h05,
                8'h80, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h06, 8'h00, 8'h03};
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], i == 5 || i == 13);
        chk("ts_type", 32'(fPktType), 32'h4);
        chk("ts_ch", 32'(ch_ID), 32'h6);
        chk("ts_slot", 32'(timeslot), 32'h3);
        chk("ts_hops_kept", 32'(hops), 32'h2);
        idle(2);

        // Truncated HB: in_last on 5th byte
        pkt = '{8'h00, 8'h03, 8'h00, 8'h07, 8'h00};
        send_pkt();
        chk("trunc_err", 32'(pkt_err), 32'h1);
        chk("trunc_cnt", 32'(err_cnt), 32'h1);
        chk("trunc_src_kept", 32'(src_id), 32'hA);
        idle(2);

        // LEN > MAX_WORDS, then a good DATA packet
        pkt = '{8'h00, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt();
        pkt = '{8'hA0, 8'h01, 8'h12, 8'h34};
        send_pkt();
        chk("data_src", 32'(src_id), 32'h1234);
        chk("data_type", 32'(fPktType), 32'h5);
        idle(1);

        // Overlong CHE, CHE below minimum length, then idle gap mid-packet
        pkt = '{8'h20, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFF};
        send_pkt();
        pkt = '{8'h20, 8'h01, 8'h00, 8'h01};
        send_pkt();
        send_byte(8'h20, 1'b0); send_byte(8'h02, 1'b0); idle(3);
        pkt = '{8'h00, 8'h21, 8'h00, 8'h22};
        send_pkt();
        idle(2);

        // Reset in WLO of a TS packet
        pkt = '{8'h80, 8'h03, 8'h00, 8'h0B, 8'h00};
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], 1'b0);
        in_byte = 8'h07; in_valid = 1'b1; nrst = 1'b0;
        idle(1);
        nrst = 1'b1; in_valid = 1'b0;
        chk("mrst_type", 32'(fPktType), 32'h7);
        chk("mrst_ch", 32'(ch_ID), 32'h0);
        chk("mrst_en", 32'(en_MNI), 32'h0);
        chk("mrst_cnt", 32'(err_cnt), 32'h0);
        idle(1);
        pkt = '{8'h80, 8'h03, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h09};
        send_pkt();
        chk("post_rst_slot", 32'(timeslot), 32'h9);
        idle(2);

        // 256 one-byte packets saturate the error counter
        for (int i = 0; i < 256; i++) send_byte(8'hE0, 1'b1);
        idle(2);
        chk("sat_cnt", 32'(err_cnt), 32'hFF);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
